// File: rtl/mat_switch_pkg.sv
// Package for the inter-core switch: default vector width, vector type, data reset value.
package mat_switch_pkg;
    `include "mat_switch_type.sv"
endpackage

// File: rtl/mat_switch_slot.sv
// One single-entry mailbox: a full flag plus one vector of reals.
module mat_switch_slot
    import mat_switch_pkg::*;
#(
    parameter int SWITCH_WIDTH = SWITCH_WIDTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic wr_en,
    input  logic rd_en,
    input  real  data_in [SWITCH_WIDTH],
    output logic full,
    output real  data_out [SWITCH_WIDTH]
);

    // wr_en only arrives when empty and rd_en only when full, so they never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int w = 0; w < SWITCH_WIDTH; w++) begin
                data_out[w] <= data_in[w];
            end
        end
    end

endmodule

// File: rtl/mat_switch_type.sv
// Shared vector type and reset value for the switch fabric; pulled into mat_switch_pkg.
localparam int SWITCH_WIDTH_DEF = 16;
typedef real MatSwitchVec_t [SWITCH_WIDTH_DEF];
localparam real MAT_SWITCH_DATA_RESET = 0.0;

// File: rtl/mat_switch.sv
// Inter-core mailbox switch: one mailbox per (source, destination) pair.
// Define MAT_SWITCH_BYPASS_EN to forward a same-cycle send straight into an empty pair's recv.
module mat_switch
    import mat_switch_pkg::*;
#(
    parameter int SWITCH_WIDTH          = SWITCH_WIDTH_DEF,
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                           send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx,
    input  real                                                   send_data [SWITCH_CORE_SIZE][SWITCH_WIDTH],
    output logic [SWITCH_CORE_SIZE-1:0]                           send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                           recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                           recv_ready,
    output real                                                   recv_data [SWITCH_CORE_SIZE][SWITCH_WIDTH],
    output logic                                                  busy
);

    // Pair arrays are indexed [source][destination].
    logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_SIZE-1:0] full;
    logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_SIZE-1:0] wr_en;
    logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_SIZE-1:0] rd_en;
    logic [SWITCH_CORE_SIZE-1:0]                       send_acc;
    logic [SWITCH_CORE_SIZE-1:0]                       recv_acc;
    logic [SWITCH_CORE_SIZE-1:0]                       recv_byp;
    logic                                              busy_next;
    real                                               slot_out [SWITCH_CORE_SIZE][SWITCH_CORE_SIZE][SWITCH_WIDTH];

    for (genvar gs = 0; gs < SWITCH_CORE_SIZE; gs++) begin : g_src
        for (genvar gd = 0; gd < SWITCH_CORE_SIZE; gd++) begin : g_dst
            mat_switch_slot #(
                .SWITCH_WIDTH(SWITCH_WIDTH)
            ) u_slot (
                .clock    (clock),
                .reset    (reset),
                .wr_en    (wr_en[gs][gd]),
                .rd_en    (rd_en[gs][gd]),
                .data_in  (send_data[gs]),
                .full     (full[gs][gd]),
                .data_out (slot_out[gs][gd])
            );
        end
    end

    // A port's own pending send_ok/recv_ready masks its request for one guard cycle.
    always_comb begin
        send_acc  = '0;
        recv_acc  = '0;
        recv_byp  = '0;
        wr_en     = '0;
        rd_en     = '0;
        busy_next = 1'b0;
        for (int s = 0; s < SWITCH_CORE_SIZE; s++) begin
            send_acc[s] = send_ready[s] && !send_ok[s] && !full[s][send_core_idx[s]];
        end
        for (int d = 0; d < SWITCH_CORE_SIZE; d++) begin
            recv_acc[d] = recv_request[d] && !recv_ready[d] && full[recv_core_idx[d]][d];
`ifdef MAT_SWITCH_BYPASS_EN
            recv_byp[d] = recv_request[d] && !recv_ready[d] && send_acc[recv_core_idx[d]]
                          && (send_core_idx[recv_core_idx[d]] == SWITCH_CORE_ADDR_SIZE'(d));
`endif
        end
        for (int s = 0; s < SWITCH_CORE_SIZE; s++) begin
            for (int d = 0; d < SWITCH_CORE_SIZE; d++) begin
                wr_en[s][d] = send_acc[s] && (send_core_idx[s] == SWITCH_CORE_ADDR_SIZE'(d))
                              && !(recv_byp[d] && (recv_core_idx[d] == SWITCH_CORE_ADDR_SIZE'(s)));
                rd_en[s][d] = recv_acc[d] && (recv_core_idx[d] == SWITCH_CORE_ADDR_SIZE'(s));
                busy_next   = busy_next || (full[s][d] && !rd_en[s][d]) || wr_en[s][d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            send_ok    <= '0;
            recv_ready <= '0;
            busy       <= 1'b0;
            for (int d = 0; d < SWITCH_CORE_SIZE; d++) begin
                for (int w = 0; w < SWITCH_WIDTH; w++) begin
                    recv_data[d][w] <= MAT_SWITCH_DATA_RESET;
                end
            end
        end else begin
            send_ok    <= send_acc;
            recv_ready <= recv_acc | recv_byp;
            busy       <= busy_next;
            for (int d = 0; d < SWITCH_CORE_SIZE; d++) begin
                for (int w = 0; w < SWITCH_WIDTH; w++) begin
                    if (recv_acc[d]) begin
                        recv_data[d][w] <= slot_out[recv_core_idx[d]][d][w];
                    end else if (recv_byp[d]) begin
                        recv_data[d][w] <= send_data[recv_core_idx[d]][w];
                    end
                end
            end
        end
    end

endmodule

// File: doc/mat_switch.md
Name: mat_switch

Overview:
- Inter-core switch fabric between SWITCH_CORE_SIZE matrix cores. Each core's send and recv switch ports connect here.
- One single-entry mailbox per (source, destination) pair carries one SWITCH_WIDTH vector of reals from the source core to the destination core.
- Senders and receivers are decoupled: a send completes when the mailbox is free, and a recv completes when the mailbox is full.

Parameters:
- SWITCH_WIDTH, 16, reals per transferred vector
- SWITCH_CORE_SIZE, 4, number of attached cores
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE), core index width (derived)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- send_ready  in  [CORE]  core c requests a send
- send_core_idx  in  [CORE][ADDR]  destination of core c's send
- send_data  in  real [CORE][WIDTH]  vector from core c
- send_ok  out  [CORE]  one-cycle pulse: core c's send accepted
- recv_request  in  [CORE]  core c requests a receive
- recv_core_idx  in  [CORE][ADDR]  source core c wants to read from
- recv_ready  out  [CORE]  one-cycle pulse: recv_data valid for core c
- recv_data  out  real [CORE][WIDTH]  vector delivered to core c
- busy  out  1  at least one mailbox is full

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State:
  - full[s][d] (1 bit) and slot[s][d] (SWITCH_WIDTH reals), for every pair.
  - Self-send (s==d) is a legal loopback pair.
- Reset:
  - All full=0, send_ok=0, recv_ready=0, recv_data all 0.0, busy=0.
  - Slot contents are don't-care.
  - Reset mid-transfer discards every mailbox. No send_ok or recv_ready pulse occurs in the cycle after reset.
- Send, per source s; d=send_core_idx[s]:
  - The switch samples at edge t. If send_ready[s] && !send_ok[s] && !full[s][d]: slot[s][d]<=send_data[s], full[s][d]<=1, send_ok[s]<=1 (visible t+1).
  - Otherwise send_ok[s]<=0. The core must hold ready, idx and data stable until send_ok.
- Recv, per destination d; s=recv_core_idx[d]:
  - If recv_request[d] && !recv_ready[d] && full[s][d]: recv_data[d]<=slot[s][d], full[s][d]<=0, recv_ready[d]<=1.
  - Otherwise recv_ready[d]<=0.
  - recv_data[d] holds its last value when recv_ready is 0.
- Latency:
  - Send accept: 1 cycle when the slot is empty.
  - Recv: 1 cycle when the slot is full.
  - End-to-end minimum (no bypass): send at t, data lands t+1, recv sampled t+1, recv_ready at t+2.
- Guard cycle: inputs are ignored in any cycle where that core's own send_ok or recv_ready is high. This prevents a duplicate transfer while the core is retiring the handshake. Maximum rate is one transfer per port every 2 cycles.
- Simultaneous send and recv on the same pair in one cycle:
  - Slot full: the recv drains the old value and the send stalls (sees full). The send succeeds next cycle.
  - Slot empty: the send fills it; the recv sees empty and retries.
- Contention: a source sends to one destination at a time and a destination receives from one source at a time, so pairs never conflict. No arbitration is needed.
- busy: registered OR of all full bits after the update, so it reflects the post-edge state.
- No back-pressure timeout. A recv from a source that never sends waits forever.

Optional Feature:
- Macro: MAT_SWITCH_BYPASS_EN.
- Defined: for the pair (s,d), when the slot is empty, send_ready[s] is accepted, and recv_request[d] targets s in the same cycle:
  - send_data forwards straight to recv_data[d].
  - send_ok[s] and recv_ready[d] both pulse at t+1.
  - full stays 0.
  - End-to-end latency is 1 cycle.
- Undefined: no forwarding; the same-cycle case follows the empty-slot rule above.

Decomposition:
- Shared include mat_switch_type.sv holds:
  - typedef MatSwitchVec_t (real array of SWITCH_WIDTH).
  - Constant MAT_SWITCH_DATA_RESET = 0.0.
- Sub-module mat_switch_slot holds one mailbox (full bit, data, write-enable, read-enable, data_out). mat_switch instantiates a SWITCH_CORE_SIZE x SWITCH_CORE_SIZE generate grid of it plus the per-port send/recv muxing logic.

Test Plan:
- Basic transfer:
  - Stimulus: core0 sends [1.0..16.0] to core2; core2 requests from 0 two cycles later.
  - Required: send_ok[0] pulses at t+1, busy=1, recv_ready[2] pulses with data [1.0..16.0], then busy=0.
- Back-pressure:
  - Stimulus: core1 sends A then B to core3 with no recv.
  - Required: A is accepted; B holds send_ready with no send_ok. After core3 receives A, B is accepted the next cycle, and core3's second recv returns B.
- Guard cycle:
  - Stimulus: core0 keeps send_ready=1 continuously to core1 while core1 drains continuously.
  - Required: send_ok pulses at most every 2nd cycle. No vector is duplicated or dropped over 8 distinct vectors.
- Concurrent pairs:
  - Stimulus: cores 0->1, 1->0, 2->2 (loopback), 3->0 all send in the same cycle.
  - Required: all four send_ok pulse at t+1.
  - Required: core0 then receives from 1 and from 3 in sequence, each returning the correct data.
- Reset mid-operation:
  - Stimulus: fill three mailboxes, then assert reset for 1 cycle.
  - Required: busy=0, recv_data=0.0, and a recv from any source stalls.
- Bypass (with MAT_SWITCH_BYPASS_EN):
  - Stimulus: core2 sends 5.5 to core1 in the same cycle core1 requests from 2.
  - Required: recv_ready[1] and send_ok[2] both pulse at t+1, data=5.5, and busy stays 0.
